// File: rtl/bcd_mod_timer.sv
// bcd_mod_timer: two-digit BCD modulo counter with up/down count, preset load, run control and carry/borrow pulse.
// Define BCD_MOD_TIMER_TICK_SYNC_EN to treat clk_time as a level and count on its registered rising edge.
module bcd_mod_timer #(
    parameter int MODULUS  = 60,
    parameter bit ONE_SHOT = 1'b0
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       clk_time,
    input  logic       up_down,
    input  logic       load_enable,
    input  logic [3:0] set_value1,
    input  logic [3:0] set_value10,
    input  logic       start,
    input  logic       stop,
    output logic [3:0] dec1,
    output logic [3:0] dec10,
    output logic       dec_clk,
    output logic       running,
    output logic       done,
    output logic       load_err
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [3:0] MAX1   = 4'((MODULUS - 1) % 10);
    localparam logic [3:0] MAX10  = 4'((MODULUS - 1) / 10);
    localparam logic [7:0] MOD8   = 8'(MODULUS);
    logic [1:0] r_state, w_state;
    logic [3:0] r_dec1, r_dec10, w_dec1, w_dec10;
    logic       r_dec_clk, w_dec_clk, r_load_err, w_load_err;
    logic       w_tick, w_zero, w_max, w_one, w_load_ok;
    logic [7:0] w_load_val;
`ifdef BCD_MOD_TIMER_TICK_SYNC_EN
    logic r_tick_lvl, r_tick;
    always_ff @(posedge clk) begin
        r_tick_lvl <= reset_p ? 1'b0 : clk_time;
        r_tick     <= reset_p ? 1'b0 : clk_time & ~r_tick_lvl;
    end
    assign w_tick = r_tick;
`else
    assign w_tick = clk_time;
`endif
    assign w_zero     = r_dec1 == 4'd0 && r_dec10 == 4'd0;
    assign w_one      = r_dec1 == 4'd1 && r_dec10 == 4'd0;
    assign w_max      = r_dec1 == MAX1 && r_dec10 == MAX10;
    assign w_load_val = {4'd0, set_value10} * 8'd10 + {4'd0, set_value1};
    assign w_load_ok  = set_value1 <= 4'd9 && set_value10 <= 4'd9 && w_load_val < MOD8;
    always_comb begin
        w_state    = r_state;
        w_dec1     = r_dec1;
        w_dec10    = r_dec10;
        w_dec_clk  = 1'b0;
        w_load_err = 1'b0;
        if (load_enable) begin
            w_load_err = ~w_load_ok;
            w_dec1     = w_load_ok ? set_value1 : r_dec1;
            w_dec10    = w_load_ok ? set_value10 : r_dec10;
            w_state    = (w_load_ok && r_state == S_DONE) ? S_IDLE : r_state;
        end else if (stop) begin
            w_state = (r_state == S_RUN) ? S_IDLE : r_state;
        end else if (start) begin
            w_state = (r_state != S_IDLE) ? r_state : (ONE_SHOT && !up_down && w_zero) ? S_DONE : S_RUN;
        end else if (w_tick && r_state == S_RUN) begin
            if (up_down) begin
                w_dec_clk = w_max;
                w_dec1    = (w_max || r_dec1 == 4'd9) ? 4'd0 : r_dec1 + 4'd1;
                w_dec10   = w_max ? 4'd0 : (r_dec1 == 4'd9) ? r_dec10 + 4'd1 : r_dec10;
            end else if (w_zero) begin
                // a one-shot count already at 00 just finishes; otherwise borrow wraps to the top
                w_dec_clk = ~ONE_SHOT;
                w_dec1    = ONE_SHOT ? 4'd0 : MAX1;
                w_dec10   = ONE_SHOT ? 4'd0 : MAX10;
                w_state   = ONE_SHOT ? S_DONE : S_RUN;
            end else begin
                w_dec1    = (r_dec1 == 4'd0) ? 4'd9 : r_dec1 - 4'd1;
                w_dec10   = (r_dec1 == 4'd0) ? r_dec10 - 4'd1 : r_dec10;
                w_dec_clk = ONE_SHOT && w_one;
                w_state   = (ONE_SHOT && w_one) ? S_DONE : S_RUN;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset_p) begin
            r_state    <= S_IDLE;
            r_dec1     <= 4'd0;
            r_dec10    <= 4'd0;
            r_dec_clk  <= 1'b0;
            r_load_err <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_dec1     <= w_dec1;
            r_dec10    <= w_dec10;
            r_dec_clk  <= w_dec_clk;
            r_load_err <= w_load_err;
        end
    end
    assign dec1     = r_dec1;
    assign dec10    = r_dec10;
    assign dec_clk  = r_dec_clk;
    assign load_err = r_load_err;
    assign running  = r_state == S_RUN;
    assign done     = r_state == S_DONE;
endmodule

// File: tb/tb_bcd_mod_timer.sv
// tb_bcd_mod_timer: three counters (mod-60 wrap, mod-60 one-shot, mod-24 wrap) checked against an integer model.
module tb_bcd_mod_timer;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] tck, dir, lde, go, halt;
    logic [3:0] sv1 [3];
    logic [3:0] sv10 [3];
    logic [3:0] d1 [3];
    logic [3:0] d10 [3];
    logic [2:0] dc, rn, dn, le;
    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int m_val [3];
    int m_st [3];
    bit m_dc [3];
    bit m_er [3];
    always #4 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bcd_mod_timer #(.MODULUS(g == 2 ? 24 : 60), .ONE_SHOT(g == 1)) u_dut (
            .clk(clk), .reset_p(rst), .clk_time(tck[g]), .up_down(dir[g]),
            .load_enable(lde[g]), .set_value1(sv1[g]), .set_value10(sv10[g]),
            .start(go[g]), .stop(halt[g]), .dec1(d1[g]), .dec10(d10[g]),
            .dec_clk(dc[g]), .running(rn[g]), .done(dn[g]), .load_err(le[g]));
    end
    function automatic int modof(input int i);
        return i == 2 ? 24 : 60;
    endfunction
    // model: value as a plain integer, state 0=idle 1=run 2=done
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_val[i] = 0; m_st[i] = 0; m_dc[i] = 0; m_er[i] = 0;
            end else begin
                m_dc[i] = 0;
                m_er[i] = 0;
                if (lde[i]) begin
                    if (sv1[i] <= 9 && sv10[i] <= 9 && int'(sv10[i]) * 10 + int'(sv1[i]) < modof(i)) begin
                        m_val[i] = int'(sv10[i]) * 10 + int'(sv1[i]);
                        if (m_st[i] == 2) m_st[i] = 0;
                    end else m_er[i] = 1;
                end else if (halt[i]) begin
                    if (m_st[i] == 1) m_st[i] = 0;
                end else if (go[i]) begin
                    if (m_st[i] == 0) m_st[i] = (i == 1 && !dir[i] && m_val[i] == 0) ? 2 : 1;
                end else if (tck[i] && m_st[i] == 1) begin
                    if (dir[i]) begin
                        m_dc[i] = m_val[i] == modof(i) - 1;
                        m_val[i] = (m_val[i] + 1) % modof(i);
                    end else if (m_val[i] == 0) begin
                        if (i == 1) m_st[i] = 2;
                        else begin m_val[i] = modof(i) - 1; m_dc[i] = 1; end
                    end else begin
                        m_val[i] = m_val[i] - 1;
                        if (i == 1 && m_val[i] == 0) begin m_dc[i] = 1; m_st[i] = 2; end
                    end
                end
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (int'(d10[i]) * 10 + int'(d1[i]) != m_val[i] || d1[i] > 9 || d10[i] > 9) begin
                    bad++; $display("FAIL cyc_count[%0d] dut=%h%h model=%0d", i, d10[i], d1[i], m_val[i]);
                end
                total++;
                if ({dc[i], rn[i], dn[i], le[i]} !== {m_dc[i], m_st[i] == 1, m_st[i] == 2, m_er[i]}) begin
                    bad++;
                    $display("FAIL cyc_flags[%0d] dut dc/run/done/err=%b%b%b%b model=%b%b%b%b", i,
                             dc[i], rn[i], dn[i], le[i], m_dc[i], m_st[i] == 1, m_st[i] == 2, m_er[i]);
                end
            end
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic lit(input int i, input logic [7:0] exp, input string nm);
        total++;
        if ({d10[i], d1[i]} !== exp || m_val[i] != int'(exp[7:4]) * 10 + int'(exp[3:0])) begin
            bad++; $display("FAIL %s dut=%h%h model=%0d required=%h", nm, d10[i], d1[i], m_val[i], exp);
        end
    endtask
    task automatic lit_bit(input logic act, input logic exp, input string nm);
        total++;
        if (act !== exp) begin
            bad++; $display("FAIL %s dut=%b required=%b", nm, act, exp);
        end
    endtask
    task automatic strobe(input int i);
        tck[i] = 1'b1; step(); tck[i] = 1'b0;
    endtask
    task automatic load(input int i, input logic [3:0] t, input logic [3:0] o);
        sv10[i] = t; sv1[i] = o; lde[i] = 1'b1; step(); lde[i] = 1'b0;
    endtask
    task automatic pulse_go(input int i);
        go[i] = 1'b1; step(); go[i] = 1'b0;
    endtask
    initial begin
        logic [7:0] down_exp [7];
        logic       down_dc [7];
        down_exp = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'h59, 8'h58};
        down_dc  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        rst = 1'b1; tck = '0; dir = '0; lde = '0; go = '0; halt = '0;
        for (int i = 0; i < 3; i++) begin sv1[i] = '0; sv10[i] = '0; end
        step(); chk_en = 1'b1; step(); rst = 1'b0;
        lit(0, 8'h00, "reset_count0");
        lit_bit(rn[0] | dn[0] | dc[0] | le[0], 1'b0, "reset_flags0");
        dir[0] = 1'b1; pulse_go(0);
        lit_bit(rn[0], 1'b1, "start_running");
        for (int k = 0; k < 59; k++) begin strobe(0); step(); end
        lit(0, 8'h59, "up_to_59");
        lit_bit(dc[0], 1'b0, "no_carry_before_wrap");
        strobe(0);
        lit(0, 8'h00, "up_wrap_00");
        lit_bit(dc[0], 1'b1, "carry_after_60th");
        step();
        lit_bit(dc[0], 1'b0, "carry_one_cycle");
        halt[0] = 1'b1; step(); halt[0] = 1'b0;
        load(0, 4'd0, 4'd5);
        lit(0, 8'h05, "load_05");
        dir[0] = 1'b0; pulse_go(0);
        for (int k = 0; k < 7; k++) begin
            strobe(0);
            lit(0, down_exp[k], "down_seq");
            lit_bit(dc[0], down_dc[k], "down_borrow");
        end
        load(1, 4'd0, 4'd2); pulse_go(1);
        strobe(1);
        lit(1, 8'h01, "os_01");
        strobe(1);
        lit(1, 8'h00, "os_00");
        lit_bit(dn[1], 1'b1, "os_done");
        lit_bit(dc[1], 1'b1, "os_borrow");
        lit_bit(rn[1], 1'b0, "os_not_running");
        strobe(1);
        lit(1, 8'h00, "os_held");
        lit_bit(dc[1], 1'b0, "os_no_pulse_in_done");
        load(1, 4'd1, 4'd0);
        lit(1, 8'h10, "os_load_10");
        lit_bit(dn[1], 1'b0, "os_done_cleared");
        load(1, 4'd0, 4'd0); pulse_go(1);
        lit_bit(dn[1], 1'b1, "os_start_at_00");
        lit_bit(dc[1], 1'b0, "os_start_no_pulse");
        load(0, 4'd6, 4'd0);
        lit_bit(le[0], 1'b1, "err_60");
        lit(0, 8'h58, "err_60_kept");
        step();
        lit_bit(le[0], 1'b0, "err_one_cycle");
        load(0, 4'd0, 4'hA);
        lit_bit(le[0], 1'b1, "err_bad_ones");
        load(0, 4'd5, 4'd9);
        lit_bit(le[0], 1'b0, "ok_59");
        lit(0, 8'h59, "load_59");
        load(2, 4'd2, 4'd3);
        dir[2] = 1'b1; pulse_go(2);
        strobe(2);
        lit(2, 8'h00, "m24_wrap");
        lit_bit(dc[2], 1'b1, "m24_carry");
        for (int k = 0; k < 3; k++) strobe(2);
        halt[2] = 1'b1; step(); halt[2] = 1'b0;
        for (int k = 0; k < 5; k++) begin strobe(2); step(); end
        lit(2, 8'h03, "m24_hold");
        lit_bit(rn[2], 1'b0, "m24_stopped");
        pulse_go(2); strobe(2);
        lit(2, 8'h04, "m24_resume");
        load(0, 4'd3, 4'd7);
        dir[0] = 1'b1; tck[0] = 1'b1; rst = 1'b1; step(); tck[0] = 1'b0; rst = 1'b0;
        lit(0, 8'h00, "reset_mid_count");
        lit_bit(rn[0] | dn[0] | dc[0] | le[0], 1'b0, "reset_mid_flags");
        lit(2, 8'h00, "reset_m24");
        pulse_go(0);
        tck[0] = 1'b1; load(0, 4'd1, 4'd2); tck[0] = 1'b0;
        lit(0, 8'h12, "load_beats_strobe");
        strobe(0);
        lit(0, 8'h13, "count_after_load");
        step(); step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_mod_timer.md
Name: bcd_mod_timer

Overview:
- Parametrised two-digit BCD modulo counter with up/down mode, loadable preset, start/stop run control and carry/borrow pulse output.
- Generalises the fixed mod-60 up/down counters: the modulus is selectable, count direction is chosen at runtime, and a one-shot countdown mode ends with a done flag.
- Sits after the usec/msec/sec tick generators. Drives 7-seg digit decoders. Its dec_clk output chains to the next stage, e.g. sec into min.

Parameters:
- MODULUS, 60: count range 0..MODULUS-1. Legal values 2..100.
- ONE_SHOT, 0: 1 means a down count stops at 00 and asserts done. 0 means a down count wraps to MODULUS-1.

Ports:
- clk  in  1  system clock, 125 MHz.
- reset_p  in  1  synchronous, active-high reset.
- clk_time  in  1  single-cycle count strobe, from an edge-detected tick source.
- up_down  in  1  count direction: 1 = up, 0 = down. Sampled on every strobe.
- load_enable  in  1  load the preset into the count.
- set_value1  in  4  preset ones digit, BCD.
- set_value10  in  4  preset tens digit, BCD.
- start  in  1  single-cycle request to begin counting.
- stop  in  1  single-cycle request to pause counting.
- dec1  out  4  ones digit of the count, BCD.
- dec10  out  4  tens digit of the count, BCD.
- dec_clk  out  1  one-cycle carry (up) or borrow (down) pulse.
- running  out  1  high while in RUN.
- done  out  1  one-shot countdown has finished. Held high until cleared.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- All logic on posedge clk. No asynchronous paths.
- Reset (reset_p=1 at an edge): dec1=0, dec10=0, dec_clk=0, running=0, done=0, load_err=0, state=IDLE. Reset mid-count aborts the count immediately.
- States:
  - IDLE: count held.
  - RUN: counts on clk_time.
  - DONE: count held at 00, done=1. Reachable only when ONE_SHOT=1.
- Priority within one cycle: reset_p > load_enable > stop > start > clk_time.
- Load validity: valid only if set_value1<=9, set_value10<=9 and value = 10*set_value10+set_value1 < MODULUS.
  - Valid load: digits updated next cycle. State is unchanged, except DONE goes to IDLE and done clears.
  - Invalid load: count and state unchanged, load_err=1 for one cycle.
  - A strobe in the same cycle as a load is dropped.
- Start:
  - IDLE -> RUN.
  - If ONE_SHOT=1, up_down=0 and the count is 00: IDLE -> DONE directly, done=1, no dec_clk.
  - Start is ignored in RUN and in DONE.
- Stop: RUN -> IDLE, count retained. Ignored in other states.
- Up count (RUN, clk_time=1, up_down=1):
  - Value < MODULUS-1: increment in BCD. Ones digit 9 wraps to 0 and carries into tens.
  - Value = MODULUS-1: next value 00, dec_clk=1 for the following cycle only.
- Down count (RUN, clk_time=1, up_down=0):
  - Value > 0: decrement in BCD. Ones digit 0 wraps to 9 and borrows from tens.
  - Value = 00, ONE_SHOT=0: next value MODULUS-1 in BCD, dec_clk=1.
  - Value = 01, ONE_SHOT=1: next value 00, dec_clk=1, state -> DONE, done=1 in the same cycle.
- Latency: digits and dec_clk are registered, so they update one cycle after the strobe edge. dec_clk never exceeds one cycle; consecutive strobes give separate pulses.
- MODULUS=100: wrap value is 99. Tens digit never exceeds 9.
- Digits outside BCD are unreachable. Count is always < MODULUS.
- Direction may change between strobes. Wrap/borrow uses up_down as sampled at the strobe.

Optional Feature:
- Macro BCD_MOD_TIMER_TICK_SYNC_EN.
- Defined:
  - clk_time is treated as a level and passed through an internal rising-edge detector (one flop).
  - Counting occurs on the cycle after each 0->1 transition, adding one cycle of latency.
  - The detector flop resets to 0.
- Undefined: clk_time is used directly as the strobe, with no added latency.

Test Plan:
- MODULUS=60, ONE_SHOT=0. Reset, start, up_down=1, 60 strobes -> count 00..59 then 00; dec_clk high exactly one cycle after the 60th strobe.
- Load 05 then start, up_down=0, 7 strobes -> 04,03,02,01,00,59,58; dec_clk pulse on the 00->59 step only.
- ONE_SHOT=1. Load 02, start, down, 3 strobes -> 01, 00 with done=1 and dec_clk pulse, running=0; third strobe leaves 00. Then load 10 -> done=0, state IDLE.
- Load set_value10=6, set_value1=0 (MODULUS=60) -> load_err one cycle, count unchanged. Load 0xA ones digit -> also rejected.
- MODULUS=24. Count up from 23 -> 00 with carry. Stop mid-count -> count holds through 5 strobes. Start -> counting resumes.
- reset_p asserted in the same cycle as a strobe at count 37 -> next cycle 00, IDLE, all outputs 0. load_enable with clk_time in the same cycle -> preset wins and the strobe is dropped.
